// File: rtl/cart_mapper_pkg.sv
// +--------------------------------------------------------------+
// | cart_mapper_pkg: mapper types, address-window constants      |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

package cart_mapper_pkg;

    typedef enum logic [1:0] {
        KONAMI     = 2'd0,
        KONAMI_SCC = 2'd1,
        ASCII8     = 2'd2,
        ASCII16    = 2'd3
    } mapper_t;

    localparam logic [15:0] C_WIN_LO = 16'h4000;
    localparam logic [15:0] C_WIN_HI = 16'hC000;

    // Bank-switch windows as addr[15:11] prefixes (2 KB granularity)
    localparam logic [4:0] C_KSCC_B0 = 5'b01010;  // 5000-57FF
    localparam logic [4:0] C_KSCC_B1 = 5'b01110;  // 7000-77FF
    localparam logic [4:0] C_KSCC_B2 = 5'b10010;  // 9000-97FF
    localparam logic [4:0] C_KSCC_B3 = 5'b10110;  // B000-B7FF
    localparam logic [4:0] C_A16_B2  = 5'b01110;  // 7000-77FF
    localparam logic [4:0] C_SCC_WIN = 5'b10011;  // 9800-9FFF
    localparam logic [5:0] C_SCC_KEY = 6'h3F;

    function automatic logic [7:0] bank_reset_value(input mapper_t m, input logic [1:0] idx);
        return ((m == KONAMI) || (m == KONAMI_SCC)) ? {6'd0, idx} : 8'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cart_mapper_gen_if.sv
// +--------------------------------------------------------------+
// | cart_mapper_gen_if: CPU-side bus and translated ROM address  |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

interface cart_mapper_gen_if #(
    parameter int NUM_SLOTS = 2,
    parameter int ADDR_W    = 25
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic [15:0]       addr;
    logic [7:0]        d_from_cpu;
    logic              wr;
    logic              cs;
    logic [SLOT_W-1:0] slot;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_unmaped;
    logic              scc_sel;

    modport master (
        output addr, d_from_cpu, wr, cs, slot,
        input  mem_addr, mem_unmaped, scc_sel
    );

    modport slave (
        input  addr, d_from_cpu, wr, cs, slot,
        output mem_addr, mem_unmaped, scc_sel
    );
endinterface

`default_nettype wire

// File: rtl/cart_mapper_wdec.sv
// +--------------------------------------------------------------+
// | cart_mapper_wdec: bank-register write decoder per mapper     |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

module cart_mapper_wdec
    import cart_mapper_pkg::*;
(
    input  mapper_t     mode,
    input  logic [15:0] addr,
    input  logic        wr_en,
    output logic [3:0]  we,
    output logic        scc_update
);

    always_comb begin
        we = 4'b0000;
        if (wr_en) begin
            case (mode)
                KONAMI: begin
                    // bank0 is hard-wired to page 0 on plain Konami
                    case (addr[15:13])
                        3'd3:    we[1] = 1'b1;
                        3'd4:    we[2] = 1'b1;
                        3'd5:    we[3] = 1'b1;
                        default: ;
                    endcase
                end
                KONAMI_SCC: begin
                    case (addr[15:11])
                        C_KSCC_B0: we[0] = 1'b1;
                        C_KSCC_B1: we[1] = 1'b1;
                        C_KSCC_B2: we[2] = 1'b1;
                        C_KSCC_B3: we[3] = 1'b1;
                        default:   ;
                    endcase
                end
                ASCII8: begin
                    if (addr[15:13] == 3'd3)
                        we[addr[12:11]] = 1'b1;
                end
                ASCII16: begin
                    // 6000-6FFF selects the low page, 7000-77FF the high page
                    if (addr[15:12] == 4'h6)
                        we[0] = 1'b1;
                    else if (addr[15:11] == C_A16_B2)
                        we[2] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign scc_update = (mode == KONAMI_SCC) & we[2];

endmodule

`default_nettype wire

// File: rtl/cart_mapper_gen.sv
// +--------------------------------------------------------------+
// | cart_mapper_gen: multi-slot MSX ROM mapper (Konami/SCC/ASCII)|
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

module cart_mapper_gen
    import cart_mapper_pkg::*;
#(
    parameter int NUM_SLOTS = 2,
    parameter int BANK_W    = 8,
    parameter int ADDR_W    = 25
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_SLOTS-1:0][1:0]           mode,
    input  logic [NUM_SLOTS-1:0][ADDR_W-1:0]    rom_size,
    cart_mapper_gen_if.slave                    bus
);

    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic [NUM_SLOTS-1:0][3:0][BANK_W-1:0] r_bank;
    logic [NUM_SLOTS-1:0]                  r_scc_en;
    logic [NUM_SLOTS-1:0][1:0]             r_mode;

    mapper_t                 w_mode;
    logic [ADDR_W-1:0]       w_rom_size;
    logic                    w_scc_en;
    logic [3:0][BANK_W-1:0]  w_banks;
    logic [3:0]              w_we;
    logic                    w_scc_update;
    logic [2:0]              w_win;
    logic [1:0]              w_idx;
    logic [BANK_W+13:0]      w_full;
    logic [ADDR_W-1:0]       w_mem_addr;
    logic                    w_scc_sel;

    always_comb begin
        w_mode     = KONAMI;
        w_rom_size = '0;
        w_scc_en   = 1'b0;
        w_banks    = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (bus.slot == SLOT_W'(s)) begin
                w_mode     = mapper_t'(mode[s]);
                w_rom_size = rom_size[s];
                w_scc_en   = r_scc_en[s];
                w_banks    = r_bank[s];
            end
        end
    end

    cart_mapper_wdec u_wdec (
        .mode       (w_mode),
        .addr       (bus.addr),
        .wr_en      (bus.cs & bus.wr),
        .we         (w_we),
        .scc_update (w_scc_update)
    );

    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
            // A mode change reloads defaults and swallows any concurrent write
            if (!reset_n || (r_mode[s] != mode[s])) begin
                r_mode[s]   <= mode[s];
                r_scc_en[s] <= 1'b0;
                for (int b = 0; b < 4; b++)
                    r_bank[s][b] <= BANK_W'(bank_reset_value(mapper_t'(mode[s]), 2'(b)));
            end else if (bus.slot == SLOT_W'(s)) begin
                for (int b = 0; b < 4; b++)
                    if (w_we[b])
                        r_bank[s][b] <= BANK_W'(bus.d_from_cpu);
                if (w_scc_update)
                    r_scc_en[s] <= (bus.d_from_cpu[5:0] == C_SCC_KEY);
            end
        end
    end

    assign w_win = bus.addr[15:13] - 3'd2;
    assign w_idx = (w_mode == ASCII16) ? (w_win[1:0] & 2'b10) : w_win[1:0];

    always_comb begin
        if (w_mode == ASCII16)
            w_full = {w_banks[w_idx], bus.addr[13:0]};
        else
            w_full = {1'b0, w_banks[w_idx], bus.addr[12:0]};
    end

    assign w_mem_addr = ADDR_W'(w_full);
    assign w_scc_sel  = bus.cs & w_scc_en & (bus.addr[15:11] == C_SCC_WIN);

    assign bus.mem_addr    = w_mem_addr;
    assign bus.scc_sel     = w_scc_sel;
    assign bus.mem_unmaped = bus.cs & ~w_scc_sel &
                             ((bus.addr < C_WIN_LO) | (bus.addr >= C_WIN_HI) |
                              (w_mem_addr >= w_rom_size));

endmodule

`default_nettype wire

// File: tb/tb_cart_mapper_gen.sv
// +--------------------------------------------------------------+
// | tb_cart_mapper_gen: scoreboard bench for cart_mapper_gen     |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

module tb_cart_mapper_gen;
    import cart_mapper_pkg::*;

    typedef struct {
        logic [24:0] a;
        logic        u;
        logic        s;
        logic        ca;
    } smp_t;

    logic                 clk;
    logic                 reset_n;
    logic [1:0][1:0]      mode;
    logic [1:0][24:0]     rom_size;
    int                   n_tests;
    int                   n_fail;
    smp_t                 sb_exp[$];
    smp_t                 sb_obs[$];
    string                sb_name[$];

    cart_mapper_gen_if #(.NUM_SLOTS(2), .ADDR_W(25)) bus ();

    cart_mapper_gen #(.NUM_SLOTS(2), .BANK_W(8), .ADDR_W(25)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .mode     (mode),
        .rom_size (rom_size),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic capture(input string nm, input logic [24:0] ea, input logic eu,
                           input logic es, input logic ca);
        smp_t e, o;
        e = '{a: ea, u: eu, s: es, ca: ca};
        o = '{a: bus.mem_addr, u: bus.mem_unmaped, s: bus.scc_sel, ca: ca};
        sb_exp.push_back(e);
        sb_obs.push_back(o);
        sb_name.push_back(nm);
    endtask

    task automatic rd(input string nm, input int sl, input logic c, input logic [15:0] ad,
                      input logic [24:0] ea, input logic eu, input logic es, input logic ca);
        bus.slot = 1'(sl); bus.cs = c; bus.wr = 1'b0; bus.addr = ad;
        #2 capture(nm, ea, eu, es, ca);
        @(negedge clk);
    endtask

    // Optionally records the same-cycle (pre-write) translation
    task automatic wr(input string nm, input int sl, input logic [15:0] ad, input logic [7:0] d,
                      input logic cap, input logic [24:0] ea);
        bus.slot = 1'(sl); bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = ad; bus.d_from_cpu = d;
        #2 if (cap) capture(nm, ea, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        bus.wr = 1'b0; bus.cs = 1'b0;
    endtask

    task automatic test_reset();
        smp_t e, o; string nm;
        rd("rst_k4000", 0, 1, 16'h4000, 25'h00000, 0, 0, 1);
        rd("rst_k6000", 0, 1, 16'h6000, 25'h02000, 0, 0, 1);
        rd("rst_k8000", 0, 1, 16'h8000, 25'h04000, 0, 0, 1);
        rd("rst_kA000", 0, 1, 16'hA000, 25'h06000, 0, 0, 1);
        rd("rst_a8A000", 1, 1, 16'hA000, 25'h00000, 0, 0, 1);
        rd("rst_nocs", 0, 0, 16'h0100, 25'h0, 0, 0, 0);
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); nm = sb_name.pop_front();
            n_tests++;
            if ((e.ca && (o.a !== e.a)) || (o.u !== e.u) || (o.s !== e.s)) begin
                n_fail++;
                $display("FAIL %s: got addr=%h unm=%b scc=%b, want addr=%h unm=%b scc=%b",
                         nm, o.a, o.u, o.s, e.a, e.u, e.s);
            end
        end
    endtask

    task automatic test_konami();
        smp_t e, o; string nm;
        wr("k_same6000", 0, 16'h6000, 8'h07, 1, 25'h02000);
        wr("k_same8000", 0, 16'h8000, 8'h5A, 1, 25'h04000);
        wr("k_b0", 0, 16'h4000, 8'h01, 0, 25'h0);
        rd("k_6000", 0, 1, 16'h6000, 25'h0E000, 0, 0, 1);
        rd("k_8000", 0, 1, 16'h8000, 25'hB4000, 0, 0, 1);
        rd("k_4000_fixed", 0, 1, 16'h4000, 25'h00000, 0, 0, 1);
        rd("k_A000", 0, 1, 16'hA000, 25'h06000, 0, 0, 1);
        rd("k_other_slot", 1, 1, 16'h6000, 25'h00000, 0, 0, 1);
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); nm = sb_name.pop_front();
            n_tests++;
            if ((e.ca && (o.a !== e.a)) || (o.u !== e.u) || (o.s !== e.s)) begin
                n_fail++;
                $display("FAIL %s: got addr=%h unm=%b scc=%b, want addr=%h unm=%b scc=%b",
                         nm, o.a, o.u, o.s, e.a, e.u, e.s);
            end
        end
    endtask

    task automatic test_scc();
        smp_t e, o; string nm;
        mode[0] = KONAMI_SCC;
        @(negedge clk);
        rd("s_reload6000", 0, 1, 16'h6000, 25'h02000, 0, 0, 1);
        wr("s_w3F", 0, 16'h9000, 8'h3F, 0, 25'h0);
        rd("s_9800_on", 0, 1, 16'h9800, 25'h7F800, 0, 1, 1);
        rd("s_9000_nowin", 0, 1, 16'h9000, 25'h7F000, 0, 0, 1);
        rd("s_9800_nocs", 0, 0, 16'h9800, 25'h0, 0, 0, 0);
        wr("s_b0", 0, 16'h5000, 8'h3F, 0, 25'h0);
        rd("s_4000", 0, 1, 16'h4000, 25'h7E000, 0, 0, 1);
        wr("s_w02", 0, 16'h9000, 8'h02, 0, 25'h0);
        rd("s_9800_off", 0, 1, 16'h9800, 25'h05800, 0, 0, 1);
        rd("s_8000", 0, 1, 16'h8000, 25'h04000, 0, 0, 1);
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); nm = sb_name.pop_front();
            n_tests++;
            if ((e.ca && (o.a !== e.a)) || (o.u !== e.u) || (o.s !== e.s)) begin
                n_fail++;
                $display("FAIL %s: got addr=%h unm=%b scc=%b, want addr=%h unm=%b scc=%b",
                         nm, o.a, o.u, o.s, e.a, e.u, e.s);
            end
        end
    endtask

    task automatic test_ascii16();
        smp_t e, o; string nm;
        mode[1] = ASCII16;
        @(negedge clk);
        wr("a16_w7000", 1, 16'h7000, 8'h05, 0, 25'h0);
        rd("a16_A123", 1, 1, 16'hA123, 25'h16123, 0, 0, 1);
        rd("a16_8000", 1, 1, 16'h8000, 25'h14000, 0, 0, 1);
        wr("a16_w6800", 1, 16'h6800, 8'h09, 0, 25'h0);
        rd("a16_4000", 1, 1, 16'h4000, 25'h24000, 0, 0, 1);
        rd("a16_7FFF", 1, 1, 16'h7FFF, 25'h27FFF, 0, 0, 1);
        rd("a16_slot0", 0, 1, 16'h8000, 25'h04000, 0, 0, 1);
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); nm = sb_name.pop_front();
            n_tests++;
            if ((e.ca && (o.a !== e.a)) || (o.u !== e.u) || (o.s !== e.s)) begin
                n_fail++;
                $display("FAIL %s: got addr=%h unm=%b scc=%b, want addr=%h unm=%b scc=%b",
                         nm, o.a, o.u, o.s, e.a, e.u, e.s);
            end
        end
    endtask

    task automatic test_two_slots();
        smp_t e, o; string nm;
        mode[1] = ASCII8;
        @(negedge clk);
        wr("ts_w6800", 1, 16'h6800, 8'h03, 0, 25'h0);
        rd("ts_s1_6000", 1, 1, 16'h6000, 25'h06000, 0, 0, 1);
        rd("ts_s1_8000", 1, 1, 16'h8000, 25'h00000, 0, 0, 1);
        rd("ts_s0_6000", 0, 1, 16'h6000, 25'h02000, 0, 0, 1);
        rd("ts_s0_4000", 0, 1, 16'h4000, 25'h7E000, 0, 0, 1);
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); nm = sb_name.pop_front();
            n_tests++;
            if ((e.ca && (o.a !== e.a)) || (o.u !== e.u) || (o.s !== e.s)) begin
                n_fail++;
                $display("FAIL %s: got addr=%h unm=%b scc=%b, want addr=%h unm=%b scc=%b",
                         nm, o.a, o.u, o.s, e.a, e.u, e.s);
            end
        end
    endtask

    task automatic test_rom_size();
        smp_t e, o; string nm;
        rom_size[1] = 25'h20000;
        wr("rs_w0F", 1, 16'h6000, 8'h0F, 0, 25'h0);
        rd("rs_last_byte", 1, 1, 16'h5FFF, 25'h1FFFF, 0, 0, 1);
        wr("rs_w10", 1, 16'h6000, 8'h10, 0, 25'h0);
        rd("rs_beyond", 1, 1, 16'h4000, 25'h20000, 1, 0, 1);
        rd("rs_in_bank3", 1, 1, 16'hBFFF, 25'h01FFF, 0, 0, 1);
        rd("rs_low", 1, 1, 16'h0100, 25'h0, 1, 0, 0);
        rd("rs_high", 1, 1, 16'hC000, 25'h0, 1, 0, 0);
        rd("rs_nocs", 1, 0, 16'h0100, 25'h0, 0, 0, 0);
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); nm = sb_name.pop_front();
            n_tests++;
            if ((e.ca && (o.a !== e.a)) || (o.u !== e.u) || (o.s !== e.s)) begin
                n_fail++;
                $display("FAIL %s: got addr=%h unm=%b scc=%b, want addr=%h unm=%b scc=%b",
                         nm, o.a, o.u, o.s, e.a, e.u, e.s);
            end
        end
    endtask

    task automatic test_mode_change();
        smp_t e, o; string nm;
        mode[0] = KONAMI;
        @(negedge clk);
        rd("mc_k_4000", 0, 1, 16'h4000, 25'h00000, 0, 0, 1);
        rd("mc_k_A000", 0, 1, 16'hA000, 25'h06000, 0, 0, 1);
        mode[0] = ASCII8;
        wr("mc_drop", 0, 16'h6000, 8'h07, 0, 25'h0);
        rd("mc_a8_4000", 0, 1, 16'h4000, 25'h00000, 0, 0, 1);
        rd("mc_a8_6000", 0, 1, 16'h6000, 25'h00000, 0, 0, 1);
        rd("mc_a8_8000", 0, 1, 16'h8000, 25'h00000, 0, 0, 1);
        rd("mc_a8_A000", 0, 1, 16'hA000, 25'h00000, 0, 0, 1);
        wr("mc_w6800", 0, 16'h6800, 8'h07, 0, 25'h0);
        rd("mc_after_wr", 0, 1, 16'h6000, 25'h0E000, 0, 0, 1);
        reset_n = 1'b0;
        wr("mc_rst_wr", 0, 16'h6800, 8'h07, 0, 25'h0);
        reset_n = 1'b1;
        rd("mc_rst_s0", 0, 1, 16'h6000, 25'h00000, 0, 0, 1);
        rd("mc_rst_s1", 1, 1, 16'h4000, 25'h00000, 0, 0, 1);
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front(); o = sb_obs.pop_front(); nm = sb_name.pop_front();
            n_tests++;
            if ((e.ca && (o.a !== e.a)) || (o.u !== e.u) || (o.s !== e.s)) begin
                n_fail++;
                $display("FAIL %s: got addr=%h unm=%b scc=%b, want addr=%h unm=%b scc=%b",
                         nm, o.a, o.u, o.s, e.a, e.u, e.s);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        mode[0] = KONAMI;
        mode[1] = ASCII8;
        rom_size[0] = 25'h200000;
        rom_size[1] = 25'h200000;
        bus.addr = 16'h0; bus.d_from_cpu = 8'h0; bus.wr = 1'b0; bus.cs = 1'b0; bus.slot = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_konami();
        test_scc();
        test_ascii16();
        test_two_slots();
        test_rom_size();
        test_mode_change();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
